pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline control unit for the five-stage Y86-64 pipeline (F, D, E, M, W).
- Watches the decode-stage register-read requests (srcA/srcB), the instructions in E, M and W, and the branch outcome.
- Drives per-stage stall/bubble controls for load-use, ret, branch mispredict and exception/halt.
- Holds the ret-drain and halt state machine plus saturating performance counters.

Parameters:
- CNT_W, 32, width of performance counters
- RNONE, 4'hF, "no register" ID
- STAT_AOK, 3'd1, normal status code (HLT=2, ADR=3, INS=4)

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active low
- D_icode  in  4  icode of instruction in decode
- d_srcA  in  4  decode register-file read port A ID
- d_srcB  in  4  decode register-file read port B ID
- E_icode  in  4  icode in execute
- E_dstM  in  4  memory-load destination of instruction in execute
- e_cnd  in  1  branch/cmov condition computed in execute
- M_icode  in  4  icode in memory
- m_stat  in  3  status produced by memory stage
- W_stat  in  3  status of instruction in writeback
- F_stall  out  1  hold PC/fetch register
- D_stall  out  1  hold decode register
- D_bubble  out  1  insert nop into decode register
- E_bubble  out  1  insert nop into execute register
- M_bubble  out  1  insert nop into memory register
- W_stall  out  1  hold writeback register
- set_cc_en  out  1  condition-code update enable
- halted  out  1  pipeline frozen by exception/halt
- cyc_cnt  out  CNT_W  cycles since reset
- stall_cnt  out  CNT_W  cycles with F_stall=1 while not halted
- flush_cnt  out  CNT_W  mispredict flush events

Behaviour:
- Control outputs are combinational from inputs and registered state; state and counters update on posedge clk.
- States: RUN, RET (ret_cnt 2 bits), HALT.
- Reset (rst_n=0 at posedge): state=RUN, ret_cnt=0, all counters=0.
- While rst_n=0: D/E/M_bubble=1, all stalls=0, set_cc_en=0, halted=0.
- Condition terms:
  - load_use = E_icode in {5 mrmovq, B popq} && E_dstM!=RNONE && (E_dstM==d_srcA || E_dstM==d_srcB).
  - mispred = E_icode==7 && !e_cnd.
  - exc = W_stat!=AOK.
- Priority, highest first: exc/HALT > mispred > load_use > ret.
- HALT, or exc in any state:
  - F_stall=1, D_stall=1, E_bubble=1, M_bubble=1, W_stall=1, halted=1, set_cc_en=0.
  - Next state HALT, sticky until reset.
- mispred (RUN):
  - D_bubble=1, E_bubble=1.
  - A ret in D is discarded: ret_cnt not loaded.
  - flush_cnt++.
- load_use (RUN):
  - F_stall=1, D_stall=1, E_bubble=1.
  - If D_icode==9 as well, the ret is held in D; no RET entry that cycle.
- ret (RUN, D_icode==9, no higher condition):
  - F_stall=1, D_bubble=1.
  - Next state RET, ret_cnt=2.
- RET:
  - F_stall=1, D_bubble=1 each cycle; ret_cnt decrements.
  - Return to RUN after the cycle with ret_cnt==1.
  - Total ret penalty is exactly 3 cycles.
- set_cc_en = 0 when m_stat!=AOK or W_stat!=AOK, else 1.
  - Still 0 during reset; inhibits CC update behind a faulting instruction.
- All unlisted outputs are 0.
- Counters:
  - Saturate at all-ones.
  - cyc_cnt freezes in HALT.
  - stall_cnt counts F_stall cycles in RUN/RET only.
- Reset mid-RET or in HALT returns to RUN next cycle; no residual ret_cnt.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (IHALT..IPOPQ)
  - stat constants
  - RNONE
  - state enum encoding
- One natural sub-module: sat_counter (CNT_W, inc, rst_n), instantiated three times.

Test Plan:
- Reset → cycle 1 after release:
  - Stimulus: rst_n low 2 cycles, then high with D_icode=1, E_icode=1, W_stat=1.
  - Response: during reset D/E/M_bubble=1. After release all controls 0, set_cc_en=1, cyc_cnt increments 0,1,2.
- Load-use:
  - Stimulus: E_icode=5, E_dstM=3, d_srcA=3.
  - Response: F_stall=D_stall=E_bubble=1, stall_cnt+1.
  - Stimulus: E_dstM=F.
  - Response: no stall.
- Ret:
  - Stimulus: D_icode=9 for 1 cycle, then D_icode=1.
  - Response: F_stall=D_bubble=1 for exactly 3 consecutive cycles, then 0.
  - Stimulus: the same ret with E_icode=5, E_dstM=d_srcB.
  - Response: load-use response first, then 3-cycle ret.
- Mispredict with ret:
  - Stimulus: E_icode=7, e_cnd=0, D_icode=9.
  - Response: D_bubble=E_bubble=1 for one cycle, no RET entry, flush_cnt=1.
- Halt:
  - Stimulus: W_stat=2 for one cycle, then 1.
  - Response: halted=1 permanently, W_stall=1, set_cc_en=0, cyc_cnt frozen. Cleared only by rst_n=0.
- Exception in M:
  - Stimulus: m_stat=3, W_stat=1.
  - Response: set_cc_en=0, halted=0, no stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared Y86-64 encodings used by the pipeline control unit: icodes, status
// codes, the "no register" ID and the control FSM state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] R_NONE = 4'hF;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_RET  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline-state inputs and stage control/counter outputs exchanged
// between the datapath (master) and the control unit (slave).
interface pipe_ctrl_if #(parameter int CNT_W = 32);

  logic [3:0]       D_icode;
  logic [3:0]       d_srcA;
  logic [3:0]       d_srcB;
  logic [3:0]       E_icode;
  logic [3:0]       E_dstM;
  logic             e_cnd;
  logic [3:0]       M_icode;
  logic [2:0]       m_stat;
  logic [2:0]       W_stat;

  logic             F_stall;
  logic             D_stall;
  logic             D_bubble;
  logic             E_bubble;
  logic             M_bubble;
  logic             W_stall;
  logic             set_cc_en;
  logic             halted;
  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
    input  F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted,
    input  cyc_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode, m_stat, W_stat,
    output F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc_en, halted,
    output cyc_cnt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline hazard control: load-use, ret drain, mispredict flush and
// sticky halt on exception, plus cycle/stall/flush performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [3:0] RNONE    = R_NONE,
  parameter logic [2:0] STAT_AOK = S_AOK
) (
  input logic          clk,
  input logic          rst_n,
  pipe_ctrl_if.slave   bus
);

  state_e     state_q, state_d;
  logic [1:0] ret_cnt_q, ret_cnt_d;

  logic load_use, mispred, exc, is_ret;
  logic f_stall, d_stall, d_bubble, e_bubble, m_bubble, w_stall, halt_o, set_cc;
  logic cyc_inc, stall_inc, flush_inc;

  assign load_use = (bus.E_icode == IMRMOVQ || bus.E_icode == IPOPQ) &&
                    (bus.E_dstM != RNONE) &&
                    (bus.E_dstM == bus.d_srcA || bus.E_dstM == bus.d_srcB);
  assign mispred  = (bus.E_icode == IJXX) && !bus.e_cnd;
  assign exc      = (bus.W_stat != STAT_AOK);
  assign is_ret   = (bus.D_icode == IRET);

  // M_icode is part of the pipeline view but no hazard rule depends on it.
  logic unused_m_icode;
  assign unused_m_icode = ^bus.M_icode;

  always_comb begin
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    m_bubble  = 1'b0;
    w_stall   = 1'b0;
    halt_o    = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    ret_cnt_d = ret_cnt_q;

    if (!rst_n) begin
      d_bubble  = 1'b1;
      e_bubble  = 1'b1;
      m_bubble  = 1'b1;
      state_d   = ST_RUN;
      ret_cnt_d = 2'd0;
    end else if (state_q == ST_HALT || exc) begin
      f_stall   = 1'b1;
      d_stall   = 1'b1;
      e_bubble  = 1'b1;
      m_bubble  = 1'b1;
      w_stall   = 1'b1;
      halt_o    = 1'b1;
      state_d   = ST_HALT;
      ret_cnt_d = 2'd0;
    end else if (state_q == ST_RET) begin
      f_stall  = 1'b1;
      d_bubble = 1'b1;
      if (ret_cnt_q <= 2'd1) begin
        state_d   = ST_RUN;
        ret_cnt_d = 2'd0;
      end else begin
        ret_cnt_d = ret_cnt_q - 2'd1;
      end
    end else if (mispred) begin
      // A ret sitting in D is on the wrong path, so it never starts a drain.
      d_bubble  = 1'b1;
      e_bubble  = 1'b1;
      flush_inc = 1'b1;
    end else if (load_use) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
    end else if (is_ret) begin
      f_stall   = 1'b1;
      d_bubble  = 1'b1;
      state_d   = ST_RET;
      ret_cnt_d = 2'd2;
    end

    set_cc    = rst_n && !halt_o && (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK);
    cyc_inc   = (state_q != ST_HALT);
    stall_inc = f_stall && !halt_o;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      ret_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign bus.F_stall   = f_stall;
  assign bus.D_stall   = d_stall;
  assign bus.D_bubble  = d_bubble;
  assign bus.E_bubble  = e_bubble;
  assign bus.M_bubble  = m_bubble;
  assign bus.W_stall   = w_stall;
  assign bus.halted    = halt_o;
  assign bus.set_cc_en = set_cc;

  sat_counter #(.CNT_W(CNT_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (cyc_inc),
    .cnt_o (bus.cyc_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (stall_inc),
    .cnt_o (bus.stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (flush_inc),
    .cnt_o (bus.flush_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl; a second narrow-counter instance covers saturation.
module tb_pipe_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  int   n_chk = 0;
  int   n_err = 0;
  int   exp_cyc = 0;
  bit   exp_halt = 1'b0;
  int   cyc_hold;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(32)) bus ();
  pipe_ctrl_if #(.CNT_W(2))  bus2 ();

  pipe_ctrl #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_ctrl #(.CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst2_n),
    .bus   (bus2)
  );

  // Packed control view: F_stall D_stall D_bubble E_bubble M_bubble W_stall halted set_cc_en
  function automatic logic [7:0] ctrl();
    return {bus.F_stall, bus.D_stall, bus.D_bubble, bus.E_bubble,
            bus.M_bubble, bus.W_stall, bus.halted, bus.set_cc_en};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and keep the expected cycle count in step with the driven inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      exp_cyc  = 0;
      exp_halt = 1'b0;
    end else begin
      if (!exp_halt) exp_cyc++;
      if (bus.W_stat != 3'd1) exp_halt = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd  = 1'b0;
    bus.M_icode = 4'h1; bus.m_stat = 3'd1; bus.W_stat = 3'd1;

    // Second instance: permanent load-use so both counters climb to saturation.
    rst2_n = 1'b0;
    bus2.D_icode = 4'h1; bus2.d_srcA = 4'h2; bus2.d_srcB = 4'hF;
    bus2.E_icode = 4'h5; bus2.E_dstM = 4'h2; bus2.e_cnd  = 1'b0;
    bus2.M_icode = 4'h1; bus2.m_stat = 3'd1; bus2.W_stat = 3'd1;

    #1;
    check("rst_ctrl", ctrl(), 8'h38);
    tick();
    tick();
    rst2_n = 1'b1;
    rst_n  = 1'b1;
    #1;
    check("post_rst_ctrl", ctrl(), 8'h01);
    check("cyc0", bus.cyc_cnt, 0);
    tick();
    check("cyc1", bus.cyc_cnt, 1);
    tick();
    check("cyc2", bus.cyc_cnt, exp_cyc);

    // Load-use on srcA
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    #1 check("lu_ctrl", ctrl(), 8'hD1);
    tick();
    check("lu_stall_cnt", bus.stall_cnt, 1);
    bus.E_dstM = 4'hF;
    #1 check("lu_rnone", ctrl(), 8'h01);
    tick();
    bus.E_icode = 4'h1; bus.d_srcA = 4'hF;

    // Plain ret: three drain cycles
    bus.D_icode = 4'h9;
    #1 check("ret_c0", ctrl(), 8'hA1);
    tick();
    bus.D_icode = 4'h1;
    #1 check("ret_c1", ctrl(), 8'hA1);
    tick();
    check("ret_c2", ctrl(), 8'hA1);
    tick();
    check("ret_done", ctrl(), 8'h01);

    // Ret held behind a load-use on srcB
    bus.D_icode = 4'h9; bus.E_icode = 4'h5; bus.E_dstM = 4'h4; bus.d_srcB = 4'h4;
    #1 check("luret_lu", ctrl(), 8'hD1);
    tick();
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.d_srcB = 4'hF;
    #1 check("luret_c0", ctrl(), 8'hA1);
    tick();
    bus.D_icode = 4'h1;
    #1 check("luret_c1", ctrl(), 8'hA1);
    tick();
    check("luret_c2", ctrl(), 8'hA1);
    tick();
    check("luret_done", ctrl(), 8'h01);
    check("stall_cnt8", bus.stall_cnt, 8);

    // Mispredict with a ret in decode
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0; bus.D_icode = 4'h9;
    #1 check("mis_ctrl", ctrl(), 8'h31);
    tick();
    bus.E_icode = 4'h1; bus.D_icode = 4'h1;
    #1 check("mis_no_ret", ctrl(), 8'h01);
    check("flush1", bus.flush_cnt, 1);
    tick();
    bus.E_icode = 4'h7; bus.e_cnd = 1'b1;
    #1 check("jxx_taken", ctrl(), 8'h01);
    tick();
    check("flush_still1", bus.flush_cnt, 1);
    check("stall_after_mis", bus.stall_cnt, 8);
    bus.E_icode = 4'h1; bus.e_cnd = 1'b0;

    // Fault in memory stage only blocks CC update
    bus.m_stat = 3'd3;
    #1 check("m_exc", ctrl(), 8'h00);
    tick();
    bus.m_stat = 3'd1;

    // Halt: sticky, counters frozen
    bus.W_stat = 3'd2;
    #1 check("halt_c0", ctrl(), 8'hDE);
    tick();
    bus.W_stat = 3'd1;
    cyc_hold = exp_cyc;
    #1 check("halt_sticky", ctrl(), 8'hDE);
    check("halt_cyc", bus.cyc_cnt, cyc_hold);
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    tick();
    tick();
    tick();
    check("halt_ctrl_late", ctrl(), 8'hDE);
    check("halt_cyc_frozen", bus.cyc_cnt, cyc_hold);
    check("halt_stall_frozen", bus.stall_cnt, 8);
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.d_srcA = 4'hF;

    // Reset out of HALT
    rst_n = 1'b0;
    #1 check("rst_in_halt", ctrl(), 8'h38);
    tick();
    rst_n = 1'b1;
    #1 check("rst_exit_halt", ctrl(), 8'h01);
    check("rst_cyc", bus.cyc_cnt, 0);
    check("rst_stall", bus.stall_cnt, 0);
    check("rst_flush", bus.flush_cnt, 0);

    // Reset during a ret drain leaves no residue
    bus.D_icode = 4'h9;
    tick();
    bus.D_icode = 4'h1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1 check("rst_mid_ret", ctrl(), 8'h01);
    tick();
    check("rst_mid_ret_c1", ctrl(), 8'h01);
    check("cyc_after_rst", bus.cyc_cnt, exp_cyc);

    // Narrow counters saturate at all-ones
    check("sat_cyc", bus2.cyc_cnt, 2'b11);
    check("sat_stall", bus2.stall_cnt, 2'b11);
    check("sat_flush", bus2.flush_cnt, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
